video_scanner: RTL and testbench
================================

# video_scanner

Raster scan-out engine for the 256×224 monochrome framebuffer. Drives the RAM's read-only second port (address out, data in) to fetch one VRAM byte per 8 pixels, serialises bits LSB-first into a 1-bit pixel stream, and generates sync/blank timing. It also issues the two per-frame CPU interrupt requests: a mid-screen pulse and a vblank pulse, consumed by the interrupt controller as RST 1 / RST 2.

## Interface
- `ADDR_WIDTH`, 13: VRAM address width (32 bytes/line × 224 lines = 7168 bytes).
- `H_TOTAL`, 320: pixel clocks per line, including blanking. Active width is fixed at 256.
- `V_ACTIVE`, 224: active lines.
- `V_TOTAL`, 262: lines per frame.
- `H_SYNC_START` / `H_SYNC_END`, 272 / 296: `hsync_n` is low for x in [start, end).
- `V_SYNC_START` / `V_SYNC_END`, 240 / 243: `vsync_n` is low for y in [start, end).
- `MID_LINE`, 96: line that triggers `irq_mid`.
- `clk` input 1: system clock. This block has one clock.
- `rst_n` input 1: reset, asynchronous and active-low.
- `pix_ce` input 1: pixel clock enable. All state advances only on `clk` edges where `pix_ce`=1.
- `vram_addr` output ADDR_WIDTH: read address to the RAM second port. Registered.
- `vram_data` input 8: read data from the RAM second port.
- `pixel` output 1: current pixel. Forced to 0 outside the active area.
- `de` output 1: display enable, high when x<256 and y<V_ACTIVE.
- `hsync_n`, `vsync_n` output 1: sync outputs, active-low.
- `irq_mid`, `irq_vblank` output 1: single-`clk` request pulses.
- `x` output 9, `y` output 9: current raster position.

## Operation
- **Counters.** Each `pix_ce` advances x. When x reaches H_TOTAL-1 it wraps to 0 and y advances. When y reaches V_TOTAL-1 it wraps to 0. There is no other state machine; timing regions are decoded from (x,y).
- **Address formation.** Address = {y[7:0], byte[4:0]}, i.e. y·32 + x/8. This is concatenation only; no multiplier.
- **Prefetch.**
  - On the `pix_ce` edge that moves the counters to (x,y) with x%8==7 and x<255, `vram_addr` ← {y, (x+1)/8}.
  - On the edge that moves the counters to x==H_TOTAL-1:
    - If the next line ny=(y+1) mod V_TOTAL is below V_ACTIVE, `vram_addr` ← {ny, 5'd0}.
    - Otherwise `vram_addr` holds its value.
- **Load and shift.**
  - On the edge that moves the counters to x%8==0 with x<256, the shift register ← `vram_data`.
  - On every other `pix_ce` edge, the shift register shifts right by 1, with zero fill.
- **Pixel output.** `pixel` = shreg[0] & `de`. So pixel(x,y) = bit (x%8) of VRAM byte y·32+x/8.
- **Interrupts.**
  - `irq_mid` pulses for one `clk` on the edge where the counters enter (0, MID_LINE).
  - `irq_vblank` pulses for one `clk` on the edge where the counters enter (0, V_ACTIVE).
  - Both pulses are independent of `pix_ce` duration.
- **Sync outputs.** `hsync_n`, `vsync_n` and `de` are registered, decoded from the next-state (x,y), so they align with `x`/`y`.

## Timing
- **Reset values.** x=H_TOTAL-1, y=V_TOTAL-1, `vram_addr`=0, shreg=0, `pixel`=0, `de`=0, `hsync_n`=1, `vsync_n`=1, `irq_mid`=0, `irq_vblank`=0.
  - The first `pix_ce` after reset moves the counters to (0,0) and loads byte 0, so no garbage first frame is produced.
- **RAM data contract.** `vram_data` must be valid one `pix_ce` period after `vram_addr` changes. The RAM second port is combinational read, so a `pix_ce` every clock is legal.
- **Latency.** Pixel (x,y) appears on `pixel` in the same cycle `x`/`y` show that position. There is zero added latency between the counters and the outputs.
- **Stalls.** With `pix_ce`=0, all outputs hold, except that the irq pulses deassert after one `clk`.
- **Wrap boundaries.**
  - Line 223 → 224: no prefetch; `vram_addr` holds 0x1BFF.
  - Line 261 → 0: prefetch 0x0000.
- **Reset mid-line.** Asynchronous; all registers return to their reset values immediately. Counting resumes at the first `pix_ce` after `rst_n` deasserts.

## Structure
- Shared include `video_defs.vh` holds the timing defaults (H_TOTAL, V_TOTAL, V_ACTIVE, sync windows, MID_LINE) and the 256 active-width constant, for reuse by the top level and the bench.
- One natural sub-module: `video_counter` (x/y counters with `pix_ce` and wrap logic, exposing next-state x/y). The fetch, shift, sync and irq logic stays in `video_scanner`.

## Test plan
- **Reset.** Hold `rst_n`=0 → all outputs at their reset values. Release with `pix_ce`=1 → after 1 clk x=0, y=0, `de`=1, and `pixel` = bit0 of mem[0].
- **Pixel order.** Fill mem[0]=0xA5 and mem[1]=0x01 → `pixel` over x=0..15 = 1,0,1,0,0,1,0,1,1,0,0,0,0,0,0,0. `vram_addr`=1 appears on the edge to x=7.
- **Last byte and blanking.** mem[0x1BFF]=0xFF → at y=223, `pixel`=1 for x=248..255. `pixel`=0 and `de`=0 at x=256..319 and for y=224..261.
- **Sync windows.** `hsync_n`=0 exactly for x=272..295 on every line. `vsync_n`=0 exactly for y=240..242.
- **Interrupts.** Over 2 frames, exactly one `irq_mid` at (0,96) and one `irq_vblank` at (0,224) per frame. Each pulse is one clk wide, including with `pix_ce` toggling every 4th clk.
- **Stall and mid-frame reset.**
  - `pix_ce` low for 10 clks at x=5 → outputs frozen, then resume with the correct bit.
  - Assert `rst_n` at (100,50) → immediate reset values. The next frame's pixels match VRAM.

Source files
------------

// File: rtl/video_scanner_pkg.sv
// rtl/video_scanner_pkg.sv - shared raster timing defaults for the video scanner and its bench
package video_scanner_pkg;

    // Active width is fixed by the 32-byte line layout of the framebuffer.
    localparam int ACTIVE_W         = 256;

    localparam int DEF_ADDR_WIDTH   = 13;
    localparam int DEF_H_TOTAL      = 320;
    localparam int DEF_V_ACTIVE     = 224;
    localparam int DEF_V_TOTAL      = 262;
    localparam int DEF_H_SYNC_START = 272;
    localparam int DEF_H_SYNC_END   = 296;
    localparam int DEF_V_SYNC_START = 240;
    localparam int DEF_V_SYNC_END   = 243;
    localparam int DEF_MID_LINE     = 96;

endpackage

// File: rtl/video_counter.sv
// rtl/video_counter.sv - x/y raster counters advanced by the pixel clock enable
module video_counter
    import video_scanner_pkg::*;
#(
    parameter int H_TOTAL = DEF_H_TOTAL,
    parameter int V_TOTAL = DEF_V_TOTAL
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_ce,
    output logic [8:0] x,
    output logic [8:0] y,
    output logic [8:0] x_next,
    output logic [8:0] y_next
);

    localparam logic [8:0] X_LAST = 9'(H_TOTAL - 1);
    localparam logic [8:0] Y_LAST = 9'(V_TOTAL - 1);

    logic [8:0] x_q, x_d;
    logic [8:0] y_q, y_d;

    // Next raster position: x wraps at line end and carries into y.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (pix_ce) begin
            if (x_q == X_LAST) begin
                x_d = 9'd0;
                y_d = (y_q == Y_LAST) ? 9'd0 : y_q + 9'd1;
            end else begin
                x_d = x_q + 9'd1;
            end
        end
    end

    // Reset parks the counters on the last pixel so the first enable lands on (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= X_LAST;
            y_q <= Y_LAST;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign x_next = x_d;
    assign y_next = y_d;

endmodule

// File: rtl/video_scanner.sv
// rtl/video_scanner.sv - framebuffer scan-out with VRAM prefetch, pixel shifter, sync and irq pulses
module video_scanner
    import video_scanner_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int H_TOTAL      = DEF_H_TOTAL,
    parameter int V_ACTIVE     = DEF_V_ACTIVE,
    parameter int V_TOTAL      = DEF_V_TOTAL,
    parameter int H_SYNC_START = DEF_H_SYNC_START,
    parameter int H_SYNC_END   = DEF_H_SYNC_END,
    parameter int V_SYNC_START = DEF_V_SYNC_START,
    parameter int V_SYNC_END   = DEF_V_SYNC_END,
    parameter int MID_LINE     = DEF_MID_LINE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pix_ce,
    output logic [ADDR_WIDTH-1:0] vram_addr,
    input  logic [7:0]            vram_data,
    output logic                  pixel,
    output logic                  de,
    output logic                  hsync_n,
    output logic                  vsync_n,
    output logic                  irq_mid,
    output logic                  irq_vblank,
    output logic [8:0]            x,
    output logic [8:0]            y
);

    localparam logic [8:0] X_LAST   = 9'(H_TOTAL - 1);
    localparam logic [8:0] Y_LAST   = 9'(V_TOTAL - 1);
    localparam logic [8:0] X_ACTIVE = 9'(ACTIVE_W);
    localparam logic [8:0] Y_ACTIVE = 9'(V_ACTIVE);
    localparam logic [8:0] HS_START = 9'(H_SYNC_START);
    localparam logic [8:0] HS_END   = 9'(H_SYNC_END);
    localparam logic [8:0] VS_START = 9'(V_SYNC_START);
    localparam logic [8:0] VS_END   = 9'(V_SYNC_END);
    localparam logic [8:0] Y_MID    = 9'(MID_LINE);

    logic [8:0] nx, ny, nl;

    logic [ADDR_WIDTH-1:0] vram_addr_q, vram_addr_d;
    logic [7:0]            shreg_q, shreg_d;
    logic                  de_q, de_d;
    logic                  hsync_n_q, hsync_n_d;
    logic                  vsync_n_q, vsync_n_d;
    logic                  irq_mid_q, irq_mid_d;
    logic                  irq_vblank_q, irq_vblank_d;

    video_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .pix_ce (pix_ce),
        .x      (x),
        .y      (y),
        .x_next (nx),
        .y_next (ny)
    );

    // Everything is decoded from the next position so registered outputs line up with x/y.
    // The fetch for a byte is issued one pixel ahead of its load, matching the RAM read contract.
    always_comb begin
        nl           = (ny == Y_LAST) ? 9'd0 : ny + 9'd1;
        vram_addr_d  = vram_addr_q;
        shreg_d      = shreg_q;
        de_d         = de_q;
        hsync_n_d    = hsync_n_q;
        vsync_n_d    = vsync_n_q;
        irq_mid_d    = 1'b0;
        irq_vblank_d = 1'b0;
        if (pix_ce) begin
            if (nx[2:0] == 3'd7 && nx < 9'd255) begin
                vram_addr_d = ADDR_WIDTH'({ny[7:0], nx[7:3] + 5'd1});
            end else if (nx == X_LAST && nl < Y_ACTIVE) begin
                vram_addr_d = ADDR_WIDTH'({nl[7:0], 5'd0});
            end
            if (nx[2:0] == 3'd0 && nx < X_ACTIVE) begin
                shreg_d = vram_data;
            end else begin
                shreg_d = {1'b0, shreg_q[7:1]};
            end
            de_d         = (nx < X_ACTIVE) && (ny < Y_ACTIVE);
            hsync_n_d    = !((nx >= HS_START) && (nx < HS_END));
            vsync_n_d    = !((ny >= VS_START) && (ny < VS_END));
            irq_mid_d    = (nx == 9'd0) && (ny == Y_MID);
            irq_vblank_d = (nx == 9'd0) && (ny == Y_ACTIVE);
        end
    end

    // Output and pipeline registers; irq flops self-clear on the next clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vram_addr_q  <= '0;
            shreg_q      <= 8'd0;
            de_q         <= 1'b0;
            hsync_n_q    <= 1'b1;
            vsync_n_q    <= 1'b1;
            irq_mid_q    <= 1'b0;
            irq_vblank_q <= 1'b0;
        end else begin
            vram_addr_q  <= vram_addr_d;
            shreg_q      <= shreg_d;
            de_q         <= de_d;
            hsync_n_q    <= hsync_n_d;
            vsync_n_q    <= vsync_n_d;
            irq_mid_q    <= irq_mid_d;
            irq_vblank_q <= irq_vblank_d;
        end
    end

    assign vram_addr  = vram_addr_q;
    assign pixel      = shreg_q[0] & de_q;
    assign de         = de_q;
    assign hsync_n    = hsync_n_q;
    assign vsync_n    = vsync_n_q;
    assign irq_mid    = irq_mid_q;
    assign irq_vblank = irq_vblank_q;

endmodule

// File: tb/tb_video_scanner.sv
// tb/tb_video_scanner.sv - self-checking bench for video_scanner with a shortened vertical raster
module tb_video_scanner;
    import video_scanner_pkg::*;

    // Vertical timing shrunk so several frames fit a short run; horizontal timing is the default.
    localparam int TVA  = 16;
    localparam int TVT  = 24;
    localparam int TVSS = 18;
    localparam int TVSE = 20;
    localparam int TMID = 6;
    localparam int FRAME = DEF_H_TOTAL * TVT;

    typedef struct {
        int px;
        int py;
        bit pix;
        bit de;
        bit hs;
        bit vs;
        int addr;
    } vec_t;

    localparam int NT = 26;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_ce;
    logic [12:0] vram_addr;
    logic [7:0]  vram_data;
    logic        pixel, de, hsync_n, vsync_n, irq_mid, irq_vblank;
    logic [8:0]  x, y;

    logic [7:0]  mem [0:8191];
    vec_t        tab [NT];
    int          ti;
    bit          tab_on;
    int          checks = 0;
    int          errors = 0;
    int          ex, ey;
    int          n_mid, n_vb;

    always #5 clk = ~clk;

    assign vram_data = mem[vram_addr];

    video_scanner #(
        .ADDR_WIDTH   (13),
        .H_TOTAL      (DEF_H_TOTAL),
        .V_ACTIVE     (TVA),
        .V_TOTAL      (TVT),
        .H_SYNC_START (DEF_H_SYNC_START),
        .H_SYNC_END   (DEF_H_SYNC_END),
        .V_SYNC_START (TVSS),
        .V_SYNC_END   (TVSE),
        .MID_LINE     (TMID)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_ce     (pix_ce),
        .vram_addr  (vram_addr),
        .vram_data  (vram_data),
        .pixel      (pixel),
        .de         (de),
        .hsync_n    (hsync_n),
        .vsync_n    (vsync_n),
        .irq_mid    (irq_mid),
        .irq_vblank (irq_vblank),
        .x          (x),
        .y          (y)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at model (%0d,%0d)", name, act, exp, ex, ey);
        end
    endtask

    function automatic logic exp_pix(input int px, input int py);
        logic [7:0] b;
        b = 8'd0;
        if (px < ACTIVE_W && py < TVA) begin
            b = mem[py * 32 + px / 8];
        end
        return b[px % 8] && (px < ACTIVE_W) && (py < TVA);
    endfunction

    task automatic model_check(input bit ce);
        chk("x", 32'(x), 32'(ex));
        chk("y", 32'(y), 32'(ey));
        chk("pixel", 32'(pixel), 32'(exp_pix(ex, ey)));
        chk("de", 32'(de), 32'(ex < ACTIVE_W && ey < TVA));
        chk("hsync_n", 32'(hsync_n), 32'(!(ex >= DEF_H_SYNC_START && ex < DEF_H_SYNC_END)));
        chk("vsync_n", 32'(vsync_n), 32'(!(ey >= TVSS && ey < TVSE)));
        chk("irq_mid", 32'(irq_mid), 32'(ce && ex == 0 && ey == TMID));
        chk("irq_vblank", 32'(irq_vblank), 32'(ce && ex == 0 && ey == TVA));
        n_mid += int'(irq_mid);
        n_vb  += int'(irq_vblank);
        if (tab_on && ti < NT && tab[ti].px == ex && tab[ti].py == ey) begin
            chk("tab_pixel", 32'(pixel), 32'(tab[ti].pix));
            chk("tab_de", 32'(de), 32'(tab[ti].de));
            chk("tab_hsync_n", 32'(hsync_n), 32'(tab[ti].hs));
            chk("tab_vsync_n", 32'(vsync_n), 32'(tab[ti].vs));
            if (tab[ti].addr >= 0) chk("tab_vram_addr", 32'(vram_addr), 32'(tab[ti].addr));
            ti++;
        end
    endtask

    task automatic step(input bit ce);
        pix_ce = ce;
        @(posedge clk);
        @(negedge clk);
        if (ce) begin
            if (ex == DEF_H_TOTAL - 1) begin
                ex = 0;
                ey = (ey == TVT - 1) ? 0 : ey + 1;
            end else begin
                ex++;
            end
        end
        model_check(ce);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_x"}, 32'(x), 32'(DEF_H_TOTAL - 1));
        chk({tag, "_y"}, 32'(y), 32'(TVT - 1));
        chk({tag, "_vram_addr"}, 32'(vram_addr), 32'd0);
        chk({tag, "_pixel"}, 32'(pixel), 32'd0);
        chk({tag, "_de"}, 32'(de), 32'd0);
        chk({tag, "_hsync_n"}, 32'(hsync_n), 32'd1);
        chk({tag, "_vsync_n"}, 32'(vsync_n), 32'd1);
        chk({tag, "_irq_mid"}, 32'(irq_mid), 32'd0);
        chk({tag, "_irq_vblank"}, 32'(irq_vblank), 32'd0);
    endtask

    initial begin
        // Hand-computed checkpoints in scan order: {x, y, pixel, de, hsync_n, vsync_n, vram_addr or -1}.
        tab[0]  = '{0,   0,  1'b1, 1'b1, 1'b1, 1'b1, 0};
        tab[1]  = '{1,   0,  1'b0, 1'b1, 1'b1, 1'b1, -1};
        tab[2]  = '{2,   0,  1'b1, 1'b1, 1'b1, 1'b1, -1};
        tab[3]  = '{3,   0,  1'b0, 1'b1, 1'b1, 1'b1, -1};
        tab[4]  = '{4,   0,  1'b0, 1'b1, 1'b1, 1'b1, -1};
        tab[5]  = '{5,   0,  1'b1, 1'b1, 1'b1, 1'b1, -1};
        tab[6]  = '{6,   0,  1'b0, 1'b1, 1'b1, 1'b1, 0};
        tab[7]  = '{7,   0,  1'b1, 1'b1, 1'b1, 1'b1, 1};
        tab[8]  = '{8,   0,  1'b1, 1'b1, 1'b1, 1'b1, 1};
        tab[9]  = '{9,   0,  1'b0, 1'b1, 1'b1, 1'b1, -1};
        tab[10] = '{15,  0,  1'b0, 1'b1, 1'b1, 1'b1, 2};
        tab[11] = '{319, 14, 1'b0, 1'b0, 1'b1, 1'b1, 'h1E0};
        tab[12] = '{248, 15, 1'b1, 1'b1, 1'b1, 1'b1, 'h1FF};
        tab[13] = '{255, 15, 1'b1, 1'b1, 1'b1, 1'b1, 'h1FF};
        tab[14] = '{256, 15, 1'b0, 1'b0, 1'b1, 1'b1, -1};
        tab[15] = '{271, 15, 1'b0, 1'b0, 1'b1, 1'b1, -1};
        tab[16] = '{272, 15, 1'b0, 1'b0, 1'b0, 1'b1, -1};
        tab[17] = '{295, 15, 1'b0, 1'b0, 1'b0, 1'b1, -1};
        tab[18] = '{296, 15, 1'b0, 1'b0, 1'b1, 1'b1, -1};
        tab[19] = '{319, 15, 1'b0, 1'b0, 1'b1, 1'b1, 'h1FF};
        tab[20] = '{0,   16, 1'b0, 1'b0, 1'b1, 1'b1, 'h1FF};
        tab[21] = '{272, 17, 1'b0, 1'b0, 1'b0, 1'b1, -1};
        tab[22] = '{0,   18, 1'b0, 1'b0, 1'b1, 1'b0, -1};
        tab[23] = '{100, 19, 1'b0, 1'b0, 1'b1, 1'b0, -1};
        tab[24] = '{0,   20, 1'b0, 1'b0, 1'b1, 1'b1, -1};
        tab[25] = '{319, 23, 1'b0, 1'b0, 1'b1, 1'b1, 0};

        for (int i = 0; i < 8192; i++) mem[i] = 8'((i * 73 + 29) ^ (i >> 3));
        mem[0]     = 8'hA5;
        mem[1]     = 8'h01;
        mem['h1FF] = 8'hFF;

        ti = 0;
        tab_on = 1'b0;
        n_mid = 0;
        n_vb = 0;
        ex = DEF_H_TOTAL - 1;
        ey = TVT - 1;

        // Reset held: outputs at reset values even with clocks running.
        rst_n  = 1'b0;
        pix_ce = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("rst");

        // Release: first enable lands on (0,0) with byte 0 loaded.
        rst_n = 1'b1;
        tab_on = 1'b1;
        step(1'b1);
        chk("first_x", 32'(x), 32'd0);
        chk("first_y", 32'(y), 32'd0);
        chk("first_de", 32'(de), 32'd1);
        chk("first_pixel", 32'(pixel), 32'd1);

        // Frame 1 with an enable every clock.
        for (int k = 1; k < FRAME; k++) step(1'b1);
        tab_on = 1'b0;
        chk("table_entries_reached", 32'(ti), 32'(NT));
        chk("frame1_irq_mid_count", 32'(n_mid), 32'd1);
        chk("frame1_irq_vblank_count", 32'(n_vb), 32'd1);

        // Frame 2 with the enable every 4th clock; pulses must still be one clk wide.
        n_mid = 0;
        n_vb = 0;
        for (int k = 0; k < FRAME; k++) begin
            step(1'b1);
            step(1'b0);
            step(1'b0);
            step(1'b0);
        end
        chk("frame2_irq_mid_count", 32'(n_mid), 32'd1);
        chk("frame2_irq_vblank_count", 32'(n_vb), 32'd1);

        // Stall at x=5 for 10 clocks, then resume with the right bits of 0xA5.
        repeat (6) step(1'b1);
        chk("stall_pos_x", 32'(x), 32'd5);
        chk("stall_pixel_before", 32'(pixel), 32'd1);
        repeat (10) step(1'b0);
        chk("stall_pixel_held", 32'(pixel), 32'd1);
        chk("stall_addr_held", 32'(vram_addr), 32'd0);
        step(1'b1);
        chk("resume_pixel_x6", 32'(pixel), 32'd0);
        step(1'b1);
        chk("resume_pixel_x7", 32'(pixel), 32'd1);
        chk("resume_addr_x7", 32'(vram_addr), 32'd1);

        // Asynchronous reset in the middle of line 5.
        for (int k = 0; k < 4 * FRAME && !(ex == 100 && ey == 5); k++) step(1'b1);
        chk("midreset_pos_x", 32'(x), 32'd100);
        chk("midreset_pos_y", 32'(y), 32'd5);
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        ex = DEF_H_TOTAL - 1;
        ey = TVT - 1;
        n_mid = 0;
        n_vb = 0;
        for (int k = 0; k < FRAME; k++) step(1'b1);
        chk("after_reset_irq_mid_count", 32'(n_mid), 32'd1);
        chk("after_reset_irq_vblank_count", 32'(n_vb), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
